lbp_histogram: RTL and testbench
================================

// Module: lbp_histogram
// PURPOSE
//  Downstream consumer of the LBP engine's result stream (lbp_valid/lbp_addr/lbp_data/finish).
//  Accumulates a 256-bin histogram of LBP codes while the frame is produced, then streams the
//  bins out sequentially and reports the dominant code. Sits beside the LBP result memory as a
//  snooper on the same write bus; never back-pressures the LBP engine.
// PARAMETERS
//  IMG_W          128  image width in pixels; power of two
//  IMG_H          128  image height in pixels
//  ADDR_W         14   width of lbp_addr; log2(IMG_W*IMG_H)
//  CNT_W          15   bin counter width; saturating
//  EXCLUDE_BORDER 1    1: ignore pixels on row 0, row IMG_H-1, col 0, col IMG_W-1
// PORTS
//  clk         in   1        system clock; all state updates on rising edge
//  reset       in   1        asynchronous, active-low reset
//  lbp_valid   in   1        LBP result write strobe
//  lbp_addr    in   ADDR_W   pixel address of the result; row = addr/IMG_W, col = addr%IMG_W
//  lbp_data    in   8        LBP code
//  finish      in   1        LBP engine frame complete; level, sampled on the rising edge
//  hist_clr    in   1        synchronous restart pulse; honoured only in DONE
//  hist_valid  out  1        hist_bin/hist_count are valid this cycle
//  hist_bin    out  8        bin index being output
//  hist_count  out  CNT_W    count for hist_bin
//  hist_done   out  1        readout complete; max_* and pix_total are final
//  max_code    out  8        code with the largest count
//  max_count   out  CNT_W    count of max_code
//  pix_total   out  ADDR_W+1 number of accepted pixels
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset (reset=0): immediate, regardless of state. All bins = 0, state = ACCUM,
//    all outputs = 0. Takes effect mid-READOUT with no partial output after assertion.
//  - FSM: ACCUM -> READOUT -> DONE -> ACCUM.
//  - ACCUM: sample lbp_valid at each rising edge.
//    - If sampled high and the pixel is accepted: bin[lbp_data] += 1, saturating at 2^CNT_W-1,
//      and pix_total += 1.
//    - Accepted: EXCLUDE_BORDER=0, or the pixel is not on the border.
//    - Row/col come from address bit slices: col = addr[log2(IMG_W)-1:0], row = the upper bits.
//    - Single-cycle update; back-to-back strobes every cycle, including the same code
//      repeatedly, must all count.
//  - ACCUM exit: finish sampled high moves to READOUT.
//    - If lbp_valid is high in that same cycle, that sample is counted first.
//  - READOUT: starts the cycle after the finish sample.
//    - For k = 0..255 on consecutive cycles: hist_valid=1, hist_bin=k, hist_count=bin[k].
//      Exactly 256 cycles, no gaps.
//    - lbp_valid is ignored throughout READOUT and DONE.
//    - max_code/max_count track a running maximum, updated strictly on greater-than, so a tie
//      keeps the lowest code. All-zero histogram gives max_code=0, max_count=0.
//  - DONE: entered the cycle after bin 255.
//    - hist_valid=0; hist_done=1 (held); max_code, max_count and pix_total held.
//    - hist_clr=1: zero all bins, pix_total, max_*, hist_done; return to ACCUM next cycle.
//    - hist_clr in ACCUM or READOUT is ignored.
//  - Latency: the finish sample to first hist_valid is 1 cycle; to hist_done is 257 cycles.
//  - No width truncation: pix_total holds IMG_W*IMG_H; saturation applies to bins only.
// TESTING
//  T1 reset=0 mid-stream then release
//     -> all outputs 0 asynchronously; subsequent frame counts from zero.
//  T2 writes addr 129, 130, 131 with code 0x5A, plus addr 0 and addr 127 with 0x5A; finish
//     -> bin 0x5A = 3, pix_total = 3, max_code = 0x5A, max_count = 3.
//  T3 full 128x128 frame, interior code 0xFF, border code 0x00
//     -> bin 255 = 15876, all others 0; 256 hist_valid cycles; hist_done 257 cycles after finish.
//  T4 CNT_W=4, 20 interior writes of code 0x11
//     -> bin 0x11 = 15 (saturated), pix_total = 20.
//  T5 five writes each of codes 0x03 and 0x07 -> max_code = 0x03, max_count = 5.
//     Then hist_clr in DONE -> all cleared.
//  T6 lbp_valid and finish in the same cycle -> sample counted.
//     lbp_valid during READOUT -> ignored.
//     reset=0 at bin 100 -> hist_valid drops immediately.

Source files
------------

// File: rtl/lbp_histogram.sv
// Snoops the LBP result write bus and builds a 256-bin histogram of codes.
// After finish, it streams the bins out in order and reports the dominant code.
module lbp_histogram #(
    parameter int unsigned IMG_W          = 128,
    parameter int unsigned IMG_H          = 128,
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned CNT_W          = 15,
    parameter bit          EXCLUDE_BORDER = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    input  logic              hist_clr,
    output logic              hist_valid,
    output logic [7:0]        hist_bin,
    output logic [CNT_W-1:0]  hist_count,
    output logic              hist_done,
    output logic [7:0]        max_code,
    output logic [CNT_W-1:0]  max_count,
    output logic [ADDR_W:0]   pix_total
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = ADDR_W - COL_W;

    localparam logic [COL_W-1:0]  ColLast = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  RowLast = ROW_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
    localparam logic [ADDR_W:0]   PixOne  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {StAccum, StReadout, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bins_q [256];
    logic [7:0]         idx_q;
    logic [7:0]         max_code_q;
    logic [CNT_W-1:0]   max_count_q;
    logic [ADDR_W:0]    pix_total_q;

    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               on_border;
    logic               accept;
    logic               bin_full;
    logic               clear;
    logic [CNT_W-1:0]   cur_count;

    assign col       = lbp_addr[COL_W-1:0];
    assign row       = lbp_addr[ADDR_W-1:COL_W];
    assign on_border = (row == '0) || (row == RowLast) || (col == '0) || (col == ColLast);
    assign accept    = lbp_valid && (state_q == StAccum) && (!EXCLUDE_BORDER || !on_border);
    assign bin_full  = &bins_q[lbp_data];
    assign clear     = (state_q == StDone) && hist_clr;
    assign cur_count = bins_q[idx_q];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum:   if (finish) state_d = StReadout;
            StReadout: if (idx_q == 8'hFF) state_d = StDone;
            StDone:    if (hist_clr) state_d = StAccum;
            default:   state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // A sample coinciding with finish is still accepted: accept only looks at StAccum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) bins_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < 256; i++) bins_q[i] <= '0;
        end else if (accept && !bin_full) begin
            bins_q[lbp_data] <= bins_q[lbp_data] + CntOne;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_total_q <= '0;
        end else if (clear) begin
            pix_total_q <= '0;
        end else if (accept) begin
            pix_total_q <= pix_total_q + PixOne;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
        end else if (state_q == StReadout) begin
            idx_q <= idx_q + 8'd1;
        end else begin
            idx_q <= '0;
        end
    end

    // Strict greater-than keeps the lowest code on ties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_code_q  <= '0;
            max_count_q <= '0;
        end else if (clear) begin
            max_code_q  <= '0;
            max_count_q <= '0;
        end else if ((state_q == StReadout) && (cur_count > max_count_q)) begin
            max_code_q  <= idx_q;
            max_count_q <= cur_count;
        end
    end

    always_comb begin
        hist_valid = (state_q == StReadout);
        hist_bin   = hist_valid ? idx_q : '0;
        hist_count = hist_valid ? cur_count : '0;
        hist_done  = (state_q == StDone);
        max_code   = max_code_q;
        max_count  = max_count_q;
        pix_total  = pix_total_q;
    end

endmodule

// File: tb/tb_lbp_histogram.sv
// Randomised and directed checks of lbp_histogram against a count-array model.
// Two instances share stimulus: defaults, and CNT_W=4 with border pixels counted.
module tb_lbp_histogram;

    localparam int IMG_W = 128;
    localparam int IMG_H = 128;
    localparam int NPIX  = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        reset;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        hist_clr;

    logic        a_valid, a_done, b_valid, b_done;
    logic [7:0]  a_bin, a_max_code, b_bin, b_max_code;
    logic [14:0] a_count, a_max_count;
    logic [3:0]  b_count, b_max_count;
    logic [14:0] a_pix, b_pix;

    int errors = 0;
    int checks = 0;

    int cnt_int [256];
    int cnt_all [256];
    int pix_int;
    int pix_all;

    always #5 clk = ~clk;

    lbp_histogram dut_a (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_clr   (hist_clr),
        .hist_valid (a_valid),
        .hist_bin   (a_bin),
        .hist_count (a_count),
        .hist_done  (a_done),
        .max_code   (a_max_code),
        .max_count  (a_max_count),
        .pix_total  (a_pix)
    );

    lbp_histogram #(
        .CNT_W          (4),
        .EXCLUDE_BORDER (1'b0)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_clr   (hist_clr),
        .hist_valid (b_valid),
        .hist_bin   (b_bin),
        .hist_count (b_count),
        .hist_done  (b_done),
        .max_code   (b_max_code),
        .max_count  (b_max_count),
        .pix_total  (b_pix)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic bit interior(input int addr);
        int r, c;
        r = addr / IMG_W;
        c = addr % IMG_W;
        return (r > 0) && (r < IMG_H - 1) && (c > 0) && (c < IMG_W - 1);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            cnt_int[i] = 0;
            cnt_all[i] = 0;
        end
        pix_int = 0;
        pix_all = 0;
    endtask

    task automatic model_add(input int addr, input int code);
        cnt_all[code]++;
        pix_all++;
        if (interior(addr)) begin
            cnt_int[code]++;
            pix_int++;
        end
    endtask

    // Called at a negedge while accumulating; returns at the next negedge.
    task automatic send(input int addr, input int code);
        lbp_valid = 1'b1;
        lbp_addr  = 14'(addr);
        lbp_data  = 8'(code);
        model_add(addr, code);
        @(negedge clk);
        lbp_valid = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_a_valid"}, a_valid, 0);
        check_eq({tag, "_a_count"}, a_count, 0);
        check_eq({tag, "_a_done"}, a_done, 0);
        check_eq({tag, "_a_max"}, a_max_count, 0);
        check_eq({tag, "_a_code"}, a_max_code, 0);
        check_eq({tag, "_a_pix"}, a_pix, 0);
        check_eq({tag, "_b_valid"}, b_valid, 0);
        check_eq({tag, "_b_pix"}, b_pix, 0);
    endtask

    // Raise finish (optionally with a strobe), then check the whole readout.
    // abort_at >= 0 pulls reset during that bin and returns to accumulation.
    task automatic finish_frame(input bit with_valid, input int addr, input int code,
                                input int abort_at);
        int ea_code, ea_max, eb_code, eb_max;
        finish = 1'b1;
        if (with_valid) begin
            lbp_valid = 1'b1;
            lbp_addr  = 14'(addr);
            lbp_data  = 8'(code);
            model_add(addr, code);
        end
        ea_code = 0; ea_max = 0; eb_code = 0; eb_max = 0;
        for (int k = 0; k < 256; k++) begin
            if (sat(cnt_int[k], 15) > ea_max) begin
                ea_max = sat(cnt_int[k], 15);
                ea_code = k;
            end
            if (sat(cnt_all[k], 4) > eb_max) begin
                eb_max = sat(cnt_all[k], 4);
                eb_code = k;
            end
        end
        @(negedge clk);
        finish    = 1'b0;
        lbp_valid = 1'b0;
        for (int k = 0; k < 256; k++) begin
            check_eq("a_hist_valid", a_valid, 1);
            check_eq("a_hist_bin", a_bin, k);
            check_eq("a_hist_count", a_count, sat(cnt_int[k], 15));
            check_eq("a_hist_done_early", a_done, 0);
            check_eq("b_hist_valid", b_valid, 1);
            check_eq("b_hist_bin", b_bin, k);
            check_eq("b_hist_count", b_count, sat(cnt_all[k], 4));
            if (k == abort_at) begin
                #2 reset = 1'b0;
                #1 check_idle_zero("abort");
                check_eq("abort_b_count", b_count, 0);
                @(negedge clk);
                lbp_valid = 1'b0;
                reset = 1'b1;
                model_clear();
                return;
            end
            // Strobes during readout must be ignored.
            lbp_valid = 1'($urandom_range(0, 1));
            lbp_addr  = 14'($urandom_range(0, NPIX - 1));
            lbp_data  = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        lbp_valid = 1'b0;
        check_eq("a_valid_after", a_valid, 0);
        check_eq("a_hist_done", a_done, 1);
        check_eq("a_max_code", a_max_code, ea_code);
        check_eq("a_max_count", a_max_count, ea_max);
        check_eq("a_pix_total", a_pix, pix_int);
        check_eq("b_hist_done", b_done, 1);
        check_eq("b_max_code", b_max_code, eb_code);
        check_eq("b_max_count", b_max_count, eb_max);
        check_eq("b_pix_total", b_pix, pix_all);
        // DONE holds regardless of strobes or finish.
        lbp_valid = 1'b1;
        finish    = 1'b1;
        @(negedge clk);
        lbp_valid = 1'b0;
        finish    = 1'b0;
        check_eq("a_done_hold", a_done, 1);
        check_eq("a_pix_hold", a_pix, pix_int);
        check_eq("a_valid_hold", a_valid, 0);
    endtask

    task automatic clear_done();
        hist_clr = 1'b1;
        @(negedge clk);
        hist_clr = 1'b0;
        check_idle_zero("clr");
        check_eq("clr_b_done", b_done, 0);
        check_eq("clr_b_max", b_max_count, 0);
        model_clear();
    endtask

    initial begin
        reset     = 1'b0;
        lbp_valid = 1'b0;
        lbp_addr  = '0;
        lbp_data  = '0;
        finish    = 1'b0;
        hist_clr  = 1'b0;
        model_clear();
        #1 check_idle_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // T1: reset mid-stream clears everything asynchronously.
        for (int i = 0; i < 5; i++) send(129 + i, 8'h42);
        check_eq("t1_pix_pre", a_pix, 5);
        #3 reset = 1'b0;
        #1 check_idle_zero("t1");
        @(negedge clk);
        reset = 1'b1;
        model_clear();

        // T2: border pixels excluded on the default instance.
        send(129, 8'h5A);
        send(130, 8'h5A);
        send(131, 8'h5A);
        send(0, 8'h5A);
        send(127, 8'h5A);
        finish_frame(1'b0, 0, 0, -1);
        clear_done();

        // T3: full frame, interior 0xFF, border 0x00.
        for (int a = 0; a < NPIX; a++) send(a, interior(a) ? 8'hFF : 8'h00);
        check_eq("t3_model_bin255", cnt_int[255], 15876);
        finish_frame(1'b0, 0, 0, -1);
        clear_done();

        // T4: saturation on the narrow instance; hist_clr in ACCUM is ignored.
        hist_clr = 1'b1;
        send(200, 8'h11);
        hist_clr = 1'b0;
        for (int i = 0; i < 19; i++) send(300 + i, 8'h11);
        finish_frame(1'b0, 0, 0, -1);
        clear_done();

        // T5: tie keeps the lowest code.
        for (int i = 0; i < 5; i++) begin
            send(1000 + i, 8'h07);
            send(2000 + i, 8'h03);
        end
        finish_frame(1'b0, 0, 0, -1);
        clear_done();

        // T6: strobe coincident with finish counts; reset during readout.
        send(500, 8'hC3);
        finish_frame(1'b1, 600, 8'hC3, -1);
        clear_done();
        for (int i = 0; i < 30; i++) send($urandom_range(0, NPIX - 1), $urandom_range(0, 255));
        finish_frame(1'b0, 0, 0, 100);
        send(700, 8'h01);
        finish_frame(1'b0, 0, 0, -1);
        clear_done();

        // Random frames with gaps and clustered codes.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send($urandom_range(0, NPIX - 1), $urandom_range(0, 15) * (f + 1));
            end
            finish_frame(1'($urandom_range(0, 1)), $urandom_range(0, NPIX - 1),
                         $urandom_range(0, 255), -1);
            clear_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
